tt_sweep: RTL and testbench

Truth-table characterizer that sits directly upstream and downstream of a combinational logic module under test. It drives every input combination onto the module's inputs in ascending order and waits a programmable settle time at each one. It then samples the module's single-bit output and assembles the sampled bits into a truth-table word. It also compares that word against an expected table supplied at start, so synthesized gate functions can be checked in simulation or on an emulation fabric.

---
 rtl/tt_sweep.sv | 105 ++++++++++
 tb/tb_tt_sweep.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep.sv
// tt_sweep: truth-table characterizer for a combinational block under test.
// Walks dut_in through 0 .. 2^N_IN-1. Each index is held for SETTLE cycles
// and then sampled in one more cycle. The sampled dut_out bits are packed
// into truth_table, which is then compared with the expected table that was
// latched at start.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, abort   sweep request (taken only in IDLE); synchronous abort (wins)
//   expected       reference table, latched on an accepted start
//   dut_in         drive vector to the module under test
//   dut_out        sampled response from the module under test
//   busy, done     sweep in progress; one-cycle completion pulse
//   truth_table    captured table, bit i = response at index i
//   tt_valid       table complete; cleared by start, abort or reset
//   match          truth_table == latched expected, while tt_valid is high
module tt_sweep #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] truth_table,
  output logic                 tt_valid,
  output logic                 match
);
  localparam int            TW   = 1 << N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(TW - 1);
  localparam logic [7:0]    SET8 = 8'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q;   // one spare bit; the sweep stops at LAST, so it never wraps
  logic [7:0]      cnt_q;
  logic [TW-1:0]   exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  if (cnt_q == 8'd1) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == LAST) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // abort overrides everything, including a start in the same IDLE cycle
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      truth_table <= '0;
      tt_valid    <= 1'b0;
      match       <= 1'b0;
    end else if (abort) begin
      // partial table is left in place for inspection
      tt_valid <= 1'b0;
      match    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          idx_q       <= '0;
          cnt_q       <= SET8;
          exp_q       <= expected;
          truth_table <= '0;
          tt_valid    <= 1'b0;
          match       <= 1'b0;
        end
        S_DRIVE: cnt_q <= cnt_q - 8'd1;
        S_SAMPLE: begin
          truth_table[idx_q[N_IN-1:0]] <= dut_out;
          if (idx_q != LAST) begin
            idx_q <= idx_q + (N_IN+1)'(1);
            cnt_q <= SET8;
          end
        end
        S_DONE: begin
          tt_valid <= 1'b1;
          match    <= (truth_table == exp_q);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done   = (state_q == S_DONE);
  assign dut_in = busy ? idx_q[N_IN-1:0] : '0;
endmodule

// File: tb/tb_tt_sweep.sv
module tb_tt_sweep;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance: N_IN=2, SETTLE=3
  logic       start, abort;
  logic [3:0] expected, func, truth_table;
  logic [1:0] dut_in;
  logic       dut_out, busy, done, tt_valid, match;
  assign dut_out = func[dut_in];

  tt_sweep u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .truth_table(truth_table),
    .tt_valid(tt_valid), .match(match));

  // N_IN=3, SETTLE=1 instance
  logic       start1, abort1;
  logic [7:0] expected1, func1, truth_table1;
  logic [2:0] dut_in1;
  logic       dut_out1, busy1, done1, tt_valid1, match1;
  assign dut_out1 = func1[dut_in1];

  tt_sweep #(.N_IN(3), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(expected1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .truth_table(truth_table1),
    .tt_valid(tt_valid1), .match(match1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, dut_in, truth_table, tt_valid, match} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dut_in=%0h tt=%0h v=%b m=%b want all 0",
               busy, done, dut_in, truth_table, tt_valid, match);
    end
    checks++;
    if ({busy1, done1, dut_in1, truth_table1, tt_valid1, match1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_n3: got nonzero outputs want all 0");
    end
  endtask

  // full sweep against func=1101; checks drive sequence, timing and result
  task automatic test_sweep(input logic [3:0] exp_tt, input logic exp_m, input string nm);
    int   done_cyc = -1;
    logic seq_ok = 1'b1, busy_ok = 1'b1;
    expected = exp_tt; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) begin
        if (dut_in !== 2'((c-1)/4)) seq_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 17) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL %s_busy_at_done: got %b want 0", nm, busy);
        end
      end
      if (c < 17) tick();
    end
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL %s_dut_in_seq: got bad sequence want 0,1,2,3 x4", nm); end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL %s_busy: got busy drop want high cycles 1..16", nm); end
    checks++;
    if (done_cyc != 17) begin errors++; $display("FAIL %s_done_cycle: got %0d want 17", nm, done_cyc); end
    tick();
    checks++;
    if (truth_table !== 4'b1101) begin
      errors++; $display("FAIL %s_tt: got %b want 1101", nm, truth_table);
    end
    checks++;
    if (tt_valid !== 1'b1 || match !== exp_m || done !== 1'b0) begin
      errors++; $display("FAIL %s_valid_match: got v=%b m=%b d=%b want v=1 m=%b d=0",
                         nm, tt_valid, match, done, exp_m);
    end
  endtask

  task automatic test_n3();
    int done_cyc = -1;
    expected1 = 8'hA0; start1 = 1'b1; tick(); start1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done1 === 1'b1) begin done_cyc = c; break; end
      tick();
    end
    checks++;
    if (done_cyc != 17) begin errors++; $display("FAIL n3_done_cycle: got %0d want 17", done_cyc); end
    tick();
    checks++;
    if (truth_table1 !== 8'b10100000 || tt_valid1 !== 1'b1 || match1 !== 1'b1) begin
      errors++; $display("FAIL n3_tt: got tt=%b v=%b m=%b want 10100000 1 1",
                         truth_table1, tt_valid1, match1);
    end
  endtask

  task automatic test_busy_start();
    int n_done = 0, done_cyc = -1;
    expected = 4'b1101; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (done === 1'b1) begin n_done++; done_cyc = c; end
      if (c == 5) start = 1'b1;
      if (c < 17) begin tick(); start = 1'b0; end
    end
    checks++;
    if (n_done != 1 || done_cyc != 17) begin
      errors++; $display("FAIL busy_start_done: got %0d pulses at %0d want 1 at 17", n_done, done_cyc);
    end
    tick(); // cycle 18, IDLE
    checks++;
    if (tt_valid !== 1'b1) begin errors++; $display("FAIL busy_start_valid18: got %b want 1", tt_valid); end
    start = 1'b1; tick(); start = 1'b0; // cycle 19
    checks++;
    if (tt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL back_to_back: got v=%b busy=%b want v=0 busy=1", tt_valid, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    logic saw_done = 1'b0;
    // abort in IDLE clears a valid result
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (tt_valid !== 1'b0 || match !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got v=%b m=%b want 0 0", tt_valid, match);
    end
    expected = 4'b1101; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    checks++;
    if (dut_in !== 2'd2) begin errors++; $display("FAIL abort_pre_idx: got %0d want 2", dut_in); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dut_in !== 2'd0 || tt_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%b dut_in=%0d v=%b d=%b want 0 0 0 0",
                         busy, dut_in, tt_valid, done);
    end
    checks++;
    if (truth_table !== 4'b0001) begin
      errors++; $display("FAIL abort_partial_tt: got %b want 0001", truth_table);
    end
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || truth_table !== 4'b0001) begin
      errors++; $display("FAIL start_abort_same: got busy=%b tt=%b want 0 0001", busy, truth_table);
    end
  endtask

  task automatic test_async_reset();
    expected = 4'b1101; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, dut_in, truth_table, tt_valid, match} !== '0) begin
      errors++; $display("FAIL async_reset: got busy=%b dut_in=%0d tt=%b want all 0",
                         busy, dut_in, truth_table);
    end
    #2 rst_n = 1'b1;
    tick();
    test_sweep(4'b1101, 1'b1, "post_reset");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; func = 4'b1101;
    start1 = 1'b0; abort1 = 1'b0; expected1 = '0; func1 = 8'b10100000;
    tick(); tick();
    test_reset();
    #2 rst_n = 1'b1;
    tick();
    test_sweep(4'b1101, 1'b1, "match");
    test_sweep(4'b1001, 1'b0, "mismatch");
    test_n3();
    test_busy_start();
    test_sweep(4'b1101, 1'b1, "pre_abort");
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
